dcs_result_requant: RTL

- Downstream stage of the DCSformer core. Consumes its 8-word burst of 32-bit results (valid-only stream, no backpressure).
- Finds the burst maximum and picks one power-of-two shift so that the maximum fits in 8 bits. Every word of the burst is requantised with that shift.
- Outputs 8 bytes plus the shift exponent over a valid/ready handshake.
- Two-bank buffer absorbs back-to-back bursts while the consumer stalls.

---
 rtl/dcs_result_requant_if.sv | 27 ++
 rtl/dcs_result_requant.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dcs_result_requant_if.sv
// Stream bundle for dcs_result_requant: valid-only 32-bit word input,
// valid/ready byte output with shift exponent, last marker and sticky overflow.
interface dcs_result_requant_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [4:0]       out_shift;
    logic             out_last;
    logic             overflow;

    // Requantiser side
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_shift, out_last, overflow
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_shift, out_last, overflow
    );
endinterface

// File: rtl/dcs_result_requant.sv
// Burst requantiser: captures N-word result bursts into a two-bank buffer,
// picks one power-of-two shift per burst so the burst max fits in OUT_W bits,
// and streams the shifted bytes out over valid/ready.
// Optional macro RQ_ROUND_EN: round-half-up instead of truncation.
module dcs_result_requant #(
    parameter int unsigned N     = 8,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dcs_result_requant_if.slave   bus
);
    localparam int unsigned CNT_W     = $clog2(N);
    localparam int unsigned SHIFT_W   = 5;
    localparam int          MAX_SHIFT = int'(IN_W - OUT_W);
    localparam logic [IN_W-1:0] BYTE_MAX = IN_W'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {IDLE, SCALE, SEND} state_t;

    // Smallest shift that brings the burst max into OUT_W bits
    function automatic logic [SHIFT_W-1:0] pick_shift(input logic [IN_W-1:0] m);
        logic [SHIFT_W-1:0] s;
        s = SHIFT_W'(MAX_SHIFT);
        for (int i = MAX_SHIFT; i >= 0; i--) begin
            if ((m >> i) <= BYTE_MAX) s = SHIFT_W'(i);
        end
        return s;
    endfunction

    // Shift one word down to a byte, one bit of headroom for the rounding carry
    function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] x,
                                                 input logic [SHIFT_W-1:0] s);
        logic [IN_W:0] sum;
        logic [IN_W:0] y;
`ifdef RQ_ROUND_EN
        sum = {1'b0, x} + ((s != '0) ? ((IN_W+1)'(1) << (s - SHIFT_W'(1))) : '0);
`else
        sum = {1'b0, x};
`endif
        y = sum >> s;
        if (y > (IN_W+1)'(BYTE_MAX)) return '1;
        return y[OUT_W-1:0];
    endfunction

    // Buffer and capture state
    logic [IN_W-1:0]  bank_mem [2][N];
    logic [IN_W-1:0]  bank_max_q [2];
    logic [1:0]       full_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic             wr_bank_q;
    logic             drop_q;
    logic [IN_W-1:0]  run_max_q;
    logic             overflow_q;

    // Output side state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic               rd_bank_q, rd_bank_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [SHIFT_W-1:0] out_shift_q, out_shift_d;
    logic               out_last_q, out_last_d;
    logic               rd_free_c;

    logic               accept_c;
    logic               wr_last_c;
    logic               bank_set_c;
    logic [IN_W-1:0]    run_max_c;
    logic [SHIFT_W-1:0] shift_c;
    logic [CNT_W-1:0]   rd_cnt_inc_c;

    // Burst acceptance is decided on the first beat from the registered full flag
    assign accept_c   = (wr_cnt_q == '0) ? !full_q[wr_bank_q] : !drop_q;
    assign wr_last_c  = (wr_cnt_q == CNT_W'(N - 1));
    assign bank_set_c = bus.in_valid && accept_c && wr_last_c;
    assign run_max_c  = (wr_cnt_q == '0)          ? bus.in_data :
                        (bus.in_data > run_max_q) ? bus.in_data : run_max_q;
    assign shift_c      = pick_shift(bank_max_q[rd_bank_q]);
    assign rd_cnt_inc_c = rd_cnt_q + CNT_W'(1);

    // Capture counters, running max and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            run_max_q  <= '0;
            overflow_q <= 1'b0;
            for (int b = 0; b < 2; b++) bank_max_q[b] <= '0;
        end else if (bus.in_valid) begin
            wr_cnt_q <= wr_last_c ? '0 : wr_cnt_q + CNT_W'(1);
            drop_q   <= !accept_c;
            if (accept_c) begin
                run_max_q <= run_max_c;
                if (wr_last_c) begin
                    bank_max_q[wr_bank_q] <= run_max_c;
                    wr_bank_q             <= ~wr_bank_q;
                end
            end else begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Word storage, no reset needed: contents are qualified by the full flags
    always_ff @(posedge clk) begin
        if (bus.in_valid && accept_c) bank_mem[wr_bank_q][wr_cnt_q] <= bus.in_data;
    end

    // Bank full flags: set by capture, cleared by the last output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (bank_set_c && (wr_bank_q == 1'(b))) full_q[b] <= 1'b1;
                else if (rd_free_c && (rd_bank_q == 1'(b))) full_q[b] <= 1'b0;
            end
        end
    end

    // Output FSM and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_shift_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_shift_q <= out_shift_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state and next-output logic; outputs hold unless a handshake advances them
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_shift_d = out_shift_q;
        out_last_d  = out_last_q;
        rd_free_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) state_d = SCALE;
            end
            SCALE: begin
                out_shift_d = shift_c;
                out_data_d  = requant(bank_mem[rd_bank_q][0], shift_c);
                out_last_d  = 1'b0;
                out_valid_d = 1'b1;
                rd_cnt_d    = '0;
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    if (rd_cnt_q == CNT_W'(N - 1)) begin
                        rd_free_c   = 1'b1;
                        rd_bank_d   = ~rd_bank_q;
                        rd_cnt_d    = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        rd_cnt_d   = rd_cnt_inc_c;
                        out_data_d = requant(bank_mem[rd_bank_q][rd_cnt_inc_c], out_shift_q);
                        out_last_d = (rd_cnt_inc_c == CNT_W'(N - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_shift = out_shift_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;
endmodule
